// File: rtl/imem_pkg.sv
// Shared types and helpers for the synchronous instruction memory.
// State enum, default geometry and the byte-address legality check.
package imem_pkg;

  typedef enum logic {
    INIT  = 1'b0,
    READY = 1'b1
  } imem_state_e;

  localparam int unsigned DEF_DEPTH = 128;
  localparam int unsigned DEF_IDX_W = $clog2(DEF_DEPTH);

  // Word index width for a given depth.
  function automatic int unsigned idx_w(
    input int unsigned depth
  );
    return $clog2(depth);
  endfunction

  // Legal = word aligned and inside the array.
  function automatic logic addr_legal(
    input logic [63:0] addr,
    input int unsigned depth
  );
    logic [63:0] lim;
    lim = 64'(depth) * 64'd4;
    return (addr[1:0] == 2'b00) && (addr < lim);
  endfunction

endpackage

// File: rtl/imem_ram_1r1w.sv
// DEPTH x DATA_WIDTH array, one synchronous read port, one write port.
// Ports: clk, rd_en/rd_idx -> rd_data (registered), wr_en/wr_idx/wr_data.
module imem_ram_1r1w #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned IDX_W      = 7
) (
  input  logic                  clk,
  input  logic                  rd_en,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Read samples the array before this edge's write lands,
  // giving read-before-write on a same-index collision.
  always_ff @(posedge clk) begin
    if (rd_en) begin
      rd_data_q <= mem_q[rd_idx];
    end
    if (wr_en) begin
      mem_q[wr_idx] <= wr_data;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/instruction_memory_sync.sv
// Synchronous-read instruction memory with self-fill after reset.
// Ports: Clk, Reset (async high), Address/ReadEn fetch, WriteEn/
// WriteAddress/WriteData load, Instruction/InstrValid/AddrError, Busy.
module instruction_memory_sync
  import imem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DEPTH      = 128,
  parameter int unsigned INIT_MULT  = 3
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic [ADDR_WIDTH-1:0] Address,
  input  logic                  ReadEn,
  input  logic                  WriteEn,
  input  logic [ADDR_WIDTH-1:0] WriteAddress,
  input  logic [DATA_WIDTH-1:0] WriteData,
  output logic [DATA_WIDTH-1:0] Instruction,
  output logic                  InstrValid,
  output logic                  AddrError,
  output logic                  Busy
);

  localparam int unsigned IDX_W = idx_w(DEPTH);

  imem_state_e state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic valid_q, valid_d;
  logic err_q, err_d;
  logic zero_q, zero_d;

  logic rd_ok, wr_ok;
  logic ram_re, ram_we;
  logic [IDX_W-1:0] ram_widx;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  assign rd_ok = addr_legal(64'(Address), DEPTH);
  assign wr_ok = addr_legal(64'(WriteAddress), DEPTH);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    err_d     = err_q;
    zero_d    = zero_q;
    ram_re    = 1'b0;
    ram_we    = 1'b0;
    ram_widx  = WriteAddress[IDX_W+1:2];
    ram_wdata = WriteData;
    unique case (state_q)
      INIT: begin
        // Fill path owns the write port; requests are ignored.
        ram_we    = 1'b1;
        ram_widx  = cnt_q;
        ram_wdata = DATA_WIDTH'(64'(cnt_q) * 64'(INIT_MULT));
        cnt_d     = cnt_q + 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        if (ReadEn) begin
          valid_d = 1'b1;
          err_d   = ~rd_ok;
          zero_d  = ~rd_ok;
          ram_re  = rd_ok;
        end
        ram_we = WriteEn & wr_ok;
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= INIT;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  imem_ram_1r1w #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk     (Clk),
    .rd_en   (ram_re),
    .rd_idx  (Address[IDX_W+1:2]),
    .rd_data (ram_rdata),
    .wr_en   (ram_we),
    .wr_idx  (ram_widx),
    .wr_data (ram_wdata)
  );

  // The RAM read register only moves on legal fetches, so it holds
  // by itself; zero_q masks it after reset or an illegal fetch.
  assign Instruction = zero_q ? '0 : ram_rdata;
  assign InstrValid  = valid_q;
  assign AddrError   = err_q;
  assign Busy        = (state_q == INIT);

endmodule

// File: tb/tb_instruction_memory_sync.sv
// Self-checking bench for instruction_memory_sync.
// Directed table, random traffic vs. a reference model, reset cases.
module tb_instruction_memory_sync;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] Address = '0;
  logic        ReadEn = 1'b0;
  logic        WriteEn = 1'b0;
  logic [31:0] WriteAddress = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] Instruction;
  logic        InstrValid, AddrError, Busy;

  logic        s_rst = 1'b1;
  logic [31:0] s_addr = '0;
  logic        s_re = 1'b0;
  logic [7:0]  s_instr;
  logic        s_valid, s_err, s_busy;

  int vectors = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  instruction_memory_sync u_dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Address      (Address),
    .ReadEn       (ReadEn),
    .WriteEn      (WriteEn),
    .WriteAddress (WriteAddress),
    .WriteData    (WriteData),
    .Instruction  (Instruction),
    .InstrValid   (InstrValid),
    .AddrError    (AddrError),
    .Busy         (Busy)
  );

  instruction_memory_sync #(
    .DATA_WIDTH (8),
    .DEPTH      (16),
    .INIT_MULT  (5)
  ) u_small (
    .Clk          (Clk),
    .Reset        (s_rst),
    .Address      (s_addr),
    .ReadEn       (s_re),
    .WriteEn      (1'b0),
    .WriteAddress (32'd0),
    .WriteData    (8'd0),
    .Instruction  (s_instr),
    .InstrValid   (s_valid),
    .AddrError    (s_err),
    .Busy         (s_busy)
  );

  // Reference model: plain array plus an init countdown.
  logic [31:0] m_mem [128];
  int          m_init_left;
  logic [31:0] m_instr;
  logic        m_valid, m_err;

  function automatic bit legal(input logic [31:0] a);
    return (a % 4 == 0) && (a < 512);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 128; i++) m_mem[i] = 32'(i * 3);
    m_init_left = 128;
    m_instr = '0;
    m_valid = 1'b0;
    m_err = 1'b0;
  endtask

  task automatic model_edge(
    input logic re, input logic [31:0] a,
    input logic we, input logic [31:0] wa,
    input logic [31:0] wd
  );
    if (m_init_left > 0) begin
      m_init_left--;
      m_valid = 1'b0;
    end else begin
      m_valid = re;
      if (re) begin
        if (legal(a)) begin
          m_instr = m_mem[a / 4];
          m_err = 1'b0;
        end else begin
          m_instr = '0;
          m_err = 1'b1;
        end
      end
      if (we && legal(wa)) m_mem[wa / 4] = wd;
    end
  endtask

  task automatic check_model(input string name);
    logic mb;
    mb = (m_init_left > 0);
    vectors++;
    if (Instruction !== m_instr || InstrValid !== m_valid ||
        AddrError !== m_err || Busy !== mb) begin
      fails++;
      $display("FAIL %s: got i=%h v=%b e=%b b=%b want i=%h v=%b e=%b b=%b",
               name, Instruction, InstrValid, AddrError, Busy,
               m_instr, m_valid, m_err, mb);
    end
  endtask

  task automatic check_val(input string name,
                           input logic [31:0] got,
                           input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic step(
    input logic re, input logic [31:0] a,
    input logic we, input logic [31:0] wa,
    input logic [31:0] wd
  );
    ReadEn = re; Address = a;
    WriteEn = we; WriteAddress = wa; WriteData = wd;
    @(posedge Clk);
    model_edge(re, a, we, wa, wd);
    #1;
    check_model("step");
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    #1;
    model_reset();
    check_model("reset");
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  task automatic wait_init(input logic re, input logic we);
    int n;
    n = 0;
    do begin
      step(re, 32'd100, we, 32'd100, 32'hFFFF_FFFF);
      n++;
    end while (Busy && n < 300);
    check_val("init_len", 32'(n), 32'd128);
  endtask

  typedef struct {
    logic        re;
    logic [31:0] a;
    logic        we;
    logic [31:0] wa;
    logic [31:0] wd;
    logic [31:0] e_instr;
    logic        e_valid;
    logic        e_err;
  } vec_t;

  vec_t tbl [16];

  initial begin
    tbl[0]  = '{1, 0,   0, 0,  0, 32'd0,  1, 0};
    tbl[1]  = '{1, 4,   0, 0,  0, 32'd3,  1, 0};
    tbl[2]  = '{1, 8,   0, 0,  0, 32'd6,  1, 0};
    tbl[3]  = '{1, 12,  0, 0,  0, 32'd9,  1, 0};
    tbl[4]  = '{1, 16,  0, 0,  0, 32'd12, 1, 0};
    tbl[5]  = '{1, 20,  0, 0,  0, 32'd15, 1, 0};
    tbl[6]  = '{1, 40,  0, 0,  0, 32'd30, 1, 0};
    tbl[7]  = '{1, 508, 0, 0,  0, 32'd381, 1, 0};
    tbl[8]  = '{1, 512, 0, 0,  0, 32'd0,  1, 1};
    tbl[9]  = '{0, 0,   0, 0,  0, 32'd0,  0, 1};
    tbl[10] = '{1, 6,   0, 0,  0, 32'd0,  1, 1};
    tbl[11] = '{1, 20,  1, 20, 32'hDEADBEEF, 32'd15, 1, 0};
    tbl[12] = '{1, 20,  0, 0,  0, 32'hDEADBEEF, 1, 0};
    tbl[13] = '{0, 0,   1, 22, 32'h1111_1111, 32'hDEADBEEF, 0, 0};
    tbl[14] = '{1, 20,  0, 0,  0, 32'hDEADBEEF, 1, 0};
    tbl[15] = '{0, 0,   0, 0,  0, 32'hDEADBEEF, 0, 0};

    #1;
    model_reset();
    check_model("reset0");
    @(negedge Clk);
    Reset = 1'b0;
    wait_init(1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      step(tbl[i].re, tbl[i].a, tbl[i].we, tbl[i].wa, tbl[i].wd);
      check_val($sformatf("tbl%0d_i", i), Instruction, tbl[i].e_instr);
      check_val($sformatf("tbl%0d_v", i), 32'(InstrValid),
                32'(tbl[i].e_valid));
      check_val($sformatf("tbl%0d_e", i), 32'(AddrError),
                32'(tbl[i].e_err));
    end

    for (int i = 0; i < 400; i++) begin
      logic [31:0] a, wa;
      a  = $urandom_range(0, 600);
      wa = $urandom_range(0, 600);
      if ($urandom_range(0, 3) != 0) a = a & ~32'd3;
      if ($urandom_range(0, 3) != 0) wa = wa & ~32'd3;
      step(1'($urandom_range(0, 1)), a,
           ($urandom_range(0, 9) < 3), wa, $urandom);
    end

    do_reset();
    wait_init(1'b1, 1'b1);
    step(1'b1, 32'd100, 1'b0, 0, 0);
    check_val("init_ignore", Instruction, 32'd75);

    do_reset();
    for (int i = 0; i < 50; i++) step(1'b0, 0, 1'b0, 0, 0);
    do_reset();
    wait_init(1'b0, 1'b0);
    step(1'b0, 0, 1'b1, 32'd20, 32'h1234_5678);
    step(1'b1, 32'd20, 1'b0, 0, 0);
    check_val("loaded", Instruction, 32'h1234_5678);
    do_reset();
    wait_init(1'b0, 1'b0);
    step(1'b1, 32'd20, 1'b0, 0, 0);
    check_val("refill", Instruction, 32'd15);

    begin
      int n;
      #1;
      check_val("s_rst_b", 32'(s_busy), 32'd1);
      check_val("s_rst_i", 32'(s_instr), 32'd0);
      @(negedge Clk);
      s_rst = 1'b0;
      n = 0;
      do begin
        @(posedge Clk);
        #1;
        n++;
      end while (s_busy && n < 100);
      check_val("s_init_len", 32'(n), 32'd16);
      s_re = 1'b1; s_addr = 32'd60;
      @(posedge Clk); #1;
      check_val("s_60_i", 32'(s_instr), 32'd75);
      check_val("s_60_e", 32'(s_err), 32'd0);
      s_addr = 32'd64;
      @(posedge Clk); #1;
      check_val("s_64_e", 32'(s_err), 32'd1);
      check_val("s_64_v", 32'(s_valid), 32'd1);
      check_val("s_64_i", 32'(s_instr), 32'd0);
      s_re = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule

// File: doc/instruction_memory_sync.md
# instruction_memory_sync

Parametrised, synchronous-read instruction memory for the instruction fetch unit. Generalises the combinational word-indexed ROM to configurable data width, depth and init pattern. Adds:
- a registered fetch with a valid strobe;
- alignment and range checking;
- a write port for loading programs;
- a self-initialisation sequencer that fills every word with `index * INIT_MULT` after reset.

Sits between the PC register and the IF/ID pipeline register.

## Interface
- `DATA_WIDTH`, 32, instruction word width in bits
- `ADDR_WIDTH`, 32, byte-address width
- `DEPTH`, 128, number of words; power of two, ≥ 2
- `INIT_MULT`, 3, fill multiplier; word i is initialised to `i * INIT_MULT`, truncated to `DATA_WIDTH`

Ports:
- `Clk`  in  1  clock; all state changes on the rising edge
- `Reset`  in  1  asynchronous, active-high reset
- `Address`  in  `ADDR_WIDTH`  fetch byte address
- `ReadEn`  in  1  fetch request, sampled on the clock edge
- `WriteEn`  in  1  write request, sampled on the clock edge
- `WriteAddress`  in  `ADDR_WIDTH`  write byte address
- `WriteData`  in  `DATA_WIDTH`  write word
- `Instruction`  out  `DATA_WIDTH`  registered fetch data
- `InstrValid`  out  1  one-cycle strobe: `Instruction`/`AddrError` are updated for an accepted fetch
- `AddrError`  out  1  accepted fetch was misaligned or out of range
- `Busy`  out  1  initialisation in progress; requests are ignored

## Operation
- Word index = `Address[log2(DEPTH)+1:2]`.
- An address is legal iff `Address[1:0] == 0` and `Address < DEPTH*4`.
- State machine, 2 states:
  - `INIT`: fill counter `cnt` runs 0..DEPTH-1. Each edge writes `mem[cnt] = cnt * INIT_MULT`. At `cnt == DEPTH-1` the state goes to `READY`. `ReadEn` and `WriteEn` are ignored.
  - `READY`: serves fetches and writes. Stays in `READY` until `Reset`.
- `Busy = (state == INIT)`.
- Fetch (`READY`, `ReadEn == 1`):
  - Next cycle `InstrValid = 1`.
  - Legal address: `Instruction = mem[idx]`, `AddrError = 0`.
  - Illegal address: `Instruction = 0`, `AddrError = 1`.
- No accepted fetch: `InstrValid = 0`. `Instruction` and `AddrError` hold their previous values.
- Write (`READY`, `WriteEn == 1`, legal `WriteAddress`): `mem[widx] = WriteData` at the edge.
- Illegal write address: the write is silently dropped and the memory is unchanged.
- Read and write to the same index in the same cycle: the fetch returns the old data (read-before-write). The new data is visible to the next fetch.
- `Reset` asserted at any time, including mid-INIT or mid-fetch:
  - state → `INIT`, `cnt` → 0;
  - `Instruction` = 0, `InstrValid` = 0, `AddrError` = 0, `Busy` = 1;
  - after release the full fill restarts and overwrites any loaded program.

## Timing
- Reset values: `Instruction` 0, `InstrValid` 0, `AddrError` 0, `Busy` 1.
- Init duration: exactly `DEPTH` rising edges after `Reset` deasserts. `Busy` falls after the DEPTH-th edge.
- The first fetch is accepted on the first edge with `Busy == 0`.
- Fetch latency: 1 cycle, from the sampling edge to `InstrValid`/`Instruction`.
- Throughput: one fetch per cycle, back-to-back.
- Write latency: the data is readable by a fetch sampled on the following edge.

## Structure
- Shared package `imem_pkg`:
  - state enum {`INIT`, `READY`};
  - index-width constant derived from `DEPTH`;
  - legality-check function.
- One sub-module, `imem_ram_1r1w`: a `DEPTH` × `DATA_WIDTH` array with one synchronous read port and one write port, read-before-write.
- The top level holds the FSM, fill counter, address checks and output registers. The fill path is muxed into the RAM write port.

## Test plan
All scenarios use the defaults (`DEPTH` 128, `INIT_MULT` 3).
- Release reset, then fetch addresses 0, 4, 8, 12, 16, 20, 40 back-to-back → `Busy` is high for 128 edges; the returned words are 0, 3, 6, 9, 12, 15, 30, each one cycle after its request, with `InstrValid` high each cycle.
- Fetch 508 → 381, `AddrError` 0. Fetch 512 → `Instruction` 0, `AddrError` 1. Fetch 6 (misaligned) → `AddrError` 1.
- Write 0xDEADBEEF to 20 while fetching 20 in the same cycle → returns 15. Next fetch of 20 → 0xDEADBEEF. Write to 22 → dropped; fetch 20 still returns 0xDEADBEEF.
- Assert `ReadEn` and `WriteEn` every cycle during INIT → `InstrValid` stays 0. After init, fetch 100 → 75 (the INIT-time write was ignored).
- Assert `Reset` at cycle 50 of INIT and again after writing to 20 → `Busy` returns to 1 immediately. After 128 edges, fetch 20 → 15.
- Change the parameters to `DEPTH` 16, `INIT_MULT` 5, `DATA_WIDTH` 8 → `Busy` lasts 16 edges. Fetch 60 → 75. Fetch 64 → `AddrError` 1.
